counter_updown_mod: RTL and testbench

Parametrised synchronous modulo-N up/down counter with synchronous clear, parallel load, selectable wrap/saturate behaviour, a combinational terminal-count output for cascading, and registered wrap/error flags. It is the next-generation counter primitive for the counter library. It is built as a fully clocked register stage rather than a gate-level latch. It sits under any block needing a configurable divider, an event counter or a cascaded multi-digit counter.

---
 rtl/counter_updown_mod.sv | 84 ++++++++
 tb/tb_counter_updown_mod.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_updown_mod.sv
// Modulo-MOD up/down counter with synchronous clear, parallel load, wrap or
// saturate at the range limits, a combinational terminal count for cascading,
// and registered one-cycle wrap/err pulses.
module counter_updown_mod #(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MOD      = 10,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             err
);

    // The modulus may equal 2**WIDTH, so it is kept 64-bit and only the
    // top count value is narrowed to the register width.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 64'd1);

    logic             at_max;
    logic             at_zero;
    logic             load_ok;
    logic [WIDTH-1:0] next_count;
    logic             next_wrap;
    logic             next_err;

    assign at_max  = (count == MAX_VAL);
    assign at_zero = (count == '0);
    assign load_ok = (64'(load_val) < MOD);

    // Unregistered so a downstream stage can use it as its enable on the same edge.
    assign tc = en & ((up_dn & at_max) | (~up_dn & at_zero));

    always_comb begin
        next_count = count;
        next_wrap  = 1'b0;
        next_err   = 1'b0;
        if (clr) begin
            next_count = '0;
        end else if (load) begin
            if (load_ok) begin
                next_count = load_val;
            end else begin
                next_count = MAX_VAL;
                next_err   = 1'b1;
            end
        end else if (en) begin
            if (up_dn) begin
                if (!at_max) begin
                    next_count = count + WIDTH'(1);
                end else if (!SATURATE) begin
                    next_count = '0;
                    next_wrap  = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    next_count = count - WIDTH'(1);
                end else if (!SATURATE) begin
                    next_count = MAX_VAL;
                    next_wrap  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            count <= next_count;
            wrap  <= next_wrap;
            err   <= next_err;
        end
    end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed and random checks of counter_updown_mod: a wrapping MOD=10 counter,
// a saturating MOD=10 counter, a full-range MOD=16 counter and a two-digit cascade.
module tb_counter_updown_mod;

    logic       clk;
    logic       reset_n;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       up_dn;

    logic [3:0] a_count, s_count, n_count;
    logic       a_tc, s_tc, n_tc;
    logic       a_wrap, s_wrap, n_wrap;
    logic       a_err, s_err, n_err;

    logic       cas_en;
    logic [3:0] c0_count, c1_count;
    logic       c0_tc, c1_tc, c0_wrap, c1_wrap, c0_err, c1_err;

    int errors;
    int checks;
    int m_a, m_s, m_n;

    logic [17:0] exp_q[$];
    logic [7:0]  cas_q[$];

    counter_updown_mod #(.WIDTH(4), .MOD(10), .SATURATE(1'b0)) dut_a (
        .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .count(a_count), .tc(a_tc), .wrap(a_wrap), .err(a_err)
    );

    counter_updown_mod #(.WIDTH(4), .MOD(10), .SATURATE(1'b1)) dut_s (
        .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .count(s_count), .tc(s_tc), .wrap(s_wrap), .err(s_err)
    );

    counter_updown_mod #(.WIDTH(4), .MOD(16), .SATURATE(1'b0)) dut_n (
        .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .count(n_count), .tc(n_tc), .wrap(n_wrap), .err(n_err)
    );

    counter_updown_mod #(.WIDTH(4), .MOD(10), .SATURATE(1'b0)) dut_c0 (
        .clk(clk), .reset_n(reset_n), .clr(1'b0), .load(1'b0), .load_val(4'd0),
        .en(cas_en), .up_dn(1'b1), .count(c0_count), .tc(c0_tc), .wrap(c0_wrap), .err(c0_err)
    );

    counter_updown_mod #(.WIDTH(4), .MOD(10), .SATURATE(1'b0)) dut_c1 (
        .clk(clk), .reset_n(reset_n), .clr(1'b0), .load(1'b0), .load_val(4'd0),
        .en(c0_tc), .up_dn(1'b1), .count(c1_count), .tc(c1_tc), .wrap(c1_wrap), .err(c1_err)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: returns {wrap, err, new_count}
    function automatic logic [5:0] model_next(input int cur, input logic c, input logic l,
                                              input logic [3:0] lv, input logic e,
                                              input logic u, input logic sat, input int m);
        int   nxt;
        logic w;
        logic er;
        nxt = cur;
        w   = 1'b0;
        er  = 1'b0;
        if (c) begin
            nxt = 0;
        end else if (l) begin
            if (int'(lv) < m) nxt = int'(lv);
            else begin
                nxt = m - 1;
                er  = 1'b1;
            end
        end else if (e) begin
            if (u) begin
                if (cur < m - 1) nxt = cur + 1;
                else if (!sat) begin
                    nxt = 0;
                    w   = 1'b1;
                end
            end else begin
                if (cur > 0) nxt = cur - 1;
                else if (!sat) begin
                    nxt = m - 1;
                    w   = 1'b1;
                end
            end
        end
        return {w, er, 4'(nxt)};
    endfunction

    function automatic logic exp_tc(input int cur, input logic e, input logic u, input int m);
        return e & ((u & (cur == m - 1)) | (!u & (cur == 0)));
    endfunction

    // Drives one edge of stimulus on the shared counters and checks the result
    task automatic step(input logic c, input logic l, input logic [3:0] lv,
                        input logic e, input logic u);
        logic [5:0]  ra, rs, rn;
        logic        ta, ts, tn;
        logic [17:0] got;
        clr = c; load = l; load_val = lv; en = e; up_dn = u;
        ta = exp_tc(m_a, e, u, 10);
        ts = exp_tc(m_s, e, u, 10);
        tn = exp_tc(m_n, e, u, 16);
        ra = model_next(m_a, c, l, lv, e, u, 1'b0, 10);
        rs = model_next(m_s, c, l, lv, e, u, 1'b1, 10);
        rn = model_next(m_n, c, l, lv, e, u, 1'b0, 16);
        m_a = int'(ra[3:0]);
        m_s = int'(rs[3:0]);
        m_n = int'(rn[3:0]);
        exp_q.push_back({ra, rs, rn});
        #1;
        check("tc_wrap10", 32'(a_tc), 32'(ta));
        check("tc_sat10", 32'(s_tc), 32'(ts));
        check("tc_mod16", 32'(n_tc), 32'(tn));
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check("wrap10 {wrap,err,count}", 32'({a_wrap, a_err, a_count}), 32'(got[17:12]));
        check("sat10 {wrap,err,count}", 32'({s_wrap, s_err, s_count}), 32'(got[11:6]));
        check("mod16 {wrap,err,count}", 32'({n_wrap, n_err, n_count}), 32'(got[5:0]));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_a = 0; m_s = 0; m_n = 0;
        cas_en = 1'b0;
        clr = 1'b0; load = 1'b0; load_val = 4'd0;
        en = 1'b1; up_dn = 1'b1;
        reset_n = 1'b0;

        // Held in reset with enable active and a running clock
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset wrap10", 32'({a_wrap, a_err, a_count}), 32'd0);
            check("reset sat10", 32'({s_wrap, s_err, s_count}), 32'd0);
            check("reset mod16", 32'({n_wrap, n_err, n_count}), 32'd0);
            check("reset tc up", 32'(a_tc), 32'd0);
        end
        up_dn = 1'b0;
        #1;
        check("reset tc down", 32'(a_tc), 32'd1);
        en = 1'b0;
        reset_n = 1'b1;

        // Count up through the top of the range
        repeat (10) step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);

        // Clear at 7
        step(1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
        step(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);

        // Down from zero: wrap vs saturate
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);

        // Loads: in range, out of range, clr priority, en ignored
        step(1'b0, 1'b1, 4'd6, 1'b0, 1'b1);
        step(1'b0, 1'b1, 4'd12, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 4'd12, 1'b0, 1'b1);
        step(1'b0, 1'b1, 4'd3, 1'b1, 1'b1);
        step(1'b0, 1'b1, 4'd15, 1'b1, 1'b0);

        // Random mix of all controls
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 4) == 0),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset between edges with a load pending
        step(1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
        clr = 1'b0; load = 1'b1; load_val = 4'd8; en = 1'b1; up_dn = 1'b1;
        #3;
        reset_n = 1'b0;
        #1;
        check("async wrap10", 32'({a_wrap, a_err, a_count}), 32'd0);
        check("async sat10", 32'({s_wrap, s_err, s_count}), 32'd0);
        check("async mod16", 32'({n_wrap, n_err, n_count}), 32'd0);
        @(posedge clk);
        #1;
        check("async held wrap10", 32'({a_wrap, a_err, a_count}), 32'd0);
        load = 1'b0;
        reset_n = 1'b1;
        m_a = 0; m_s = 0; m_n = 0;
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        check("post reset count", 32'(a_count), 32'd1);

        // Two-digit cascade for 100 enabled cycles
        en = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            logic [7:0] got;
            cas_en = 1'b1;
            cas_q.push_back({4'((i % 100) / 10), 4'(i % 10)});
            #1;
            check("cascade tc0", 32'(c0_tc), 32'(((i - 1) % 10) == 9));
            @(posedge clk);
            #1;
            got = cas_q.pop_front();
            check("cascade digits", 32'({c1_count, c0_count}), 32'(got));
        end
        cas_en = 1'b0;
        check("cascade final", 32'({c1_count, c0_count}), 32'd0);
        check("queues drained", 32'(exp_q.size() + cas_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
